// File: rtl/imem_loader_pkg.sv
// Shared types and sizing for the writable instruction memory loader.
// Build option: IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
package imem_loader_pkg;
  typedef enum logic [2:0] {
    CLEAR, HEADER, LOAD, CHECK, DONE, ERR
  } ldr_state_t;
  localparam int DEPTH = 64;
  localparam int AW = 6;
endpackage

// File: rtl/imem_ram.sv
// 64-entry instruction store with one synchronous write port
// and one combinational read port (read-during-write returns the old word).
module imem_ram
  import imem_loader_pkg::*;
#(
  parameter int N = 32
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [N-1:0]  wdata,
  input  logic [AW-1:0] addr,
  output logic [N-1:0]  q
);
  logic [N-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign q = mem[addr];
endmodule

// File: rtl/imem_loader.sv
// Boot loader: clears the store, then writes a counted little-endian byte stream.
// Build option: IMEM_LOADER_CHECKSUM_EN enables the CHECK state and XOR checksum.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int N = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  input  logic [AW-1:0] addr,
  output logic [N-1:0]  q,
  output logic          cpu_reset,
  output logic          load_done,
  output logic          load_err,
  output logic [6:0]    words_loaded
);
  localparam int BPW = N / 8;
  localparam int BW = (BPW > 1) ? $clog2(BPW) : 1;

  ldr_state_t    state, nstate;
  logic [AW-1:0] ptr;
  logic [BW-1:0] bcnt;
  logic [N-1:0]  wbuf, asm_word;
  logic [6:0]    cnt, wcnt;
  logic          accept, last_byte;
  logic          we;
  logic [AW-1:0] waddr;
  logic [N-1:0]  wdata;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]    csum;
`endif

  assign in_ready = (state == HEADER) ||
                    (state == LOAD) ||
                    (state == CHECK);
  assign accept = in_valid && in_ready;
  assign last_byte = (bcnt == BW'(BPW - 1));

  assign cpu_reset = (state != DONE);
  assign load_done = (state == DONE);
  assign load_err = (state == ERR);
  assign words_loaded = wcnt;

  // Final byte goes straight into the top lane.
  always_comb begin
    asm_word = wbuf;
    asm_word[N-8 +: 8] = in_data;
  end

  always_comb begin
    nstate = state;
    we = 1'b0;
    waddr = ptr;
    wdata = '0;
    unique case (state)
      CLEAR: begin
        we = 1'b1;
        if (ptr == AW'(DEPTH - 1)) nstate = HEADER;
      end
      HEADER: begin
        if (accept) begin
          if (in_data == 8'd0) nstate = DONE;
          else if (in_data > 8'(DEPTH)) nstate = ERR;
          else nstate = LOAD;
        end
      end
      LOAD: begin
        if (accept && last_byte) begin
          we = 1'b1;
          waddr = wcnt[AW-1:0];
          wdata = asm_word;
          if (wcnt + 7'd1 == cnt) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            nstate = CHECK;
`else
            nstate = DONE;
`endif
          end
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHECK: begin
        if (accept) nstate = (in_data == csum) ? DONE : ERR;
      end
`endif
      default: nstate = state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= CLEAR;
      ptr <= '0;
      bcnt <= '0;
      wbuf <= '0;
      cnt <= '0;
      wcnt <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum <= '0;
`endif
    end else begin
      state <= nstate;
      if (state == CLEAR) ptr <= ptr + AW'(1);
      if (state == HEADER && accept) cnt <= in_data[6:0];
      if (state == LOAD && accept) begin
        if (last_byte) begin
          bcnt <= '0;
          wcnt <= wcnt + 7'd1;
        end else begin
          bcnt <= bcnt + BW'(1);
          wbuf[{bcnt, 3'b000} +: 8] <= in_data;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (accept) csum <= csum ^ in_data;
`endif
    end
  end

  imem_ram #(.N(N)) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .addr  (addr),
    .q     (q)
  );
endmodule

// File: tb/tb_imem_loader.sv
// Directed table-driven bench for imem_loader; expectations are hand-computed.
// Build option: IMEM_LOADER_CHECKSUM_EN selects the checksum scenarios.
module tb_imem_loader;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic [5:0]  addr = 6'd0;
  logic [31:0] q;
  logic        cpu_reset, load_done, load_err;
  logic [6:0]  words_loaded;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       rdy;
    logic       cr;
    logic       dn;
    logic       er;
    logic [6:0] w;
  } vec_t;

  vec_t tbl[$];

  imem_loader #(.N(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .addr         (addr),
    .q            (q),
    .cpu_reset    (cpu_reset),
    .load_done    (load_done),
    .load_err     (load_err),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic v, input logic [7:0] d,
                              input logic rdy, input logic cr,
                              input logic dn, input logic er,
                              input logic [6:0] w);
    vec_t t;
    t.v = v; t.d = d; t.rdy = rdy; t.cr = cr;
    t.dn = dn; t.er = er; t.w = w;
    return t;
  endfunction

  // Called at a negedge; each record checks outputs, then drives one edge.
  task automatic run_tbl(input string nm);
    foreach (tbl[i]) begin
      chk($sformatf("%s[%0d].rdy", nm, i), 32'(in_ready), 32'(tbl[i].rdy));
      chk($sformatf("%s[%0d].cr", nm, i), 32'(cpu_reset), 32'(tbl[i].cr));
      chk($sformatf("%s[%0d].dn", nm, i), 32'(load_done), 32'(tbl[i].dn));
      chk($sformatf("%s[%0d].er", nm, i), 32'(load_err), 32'(tbl[i].er));
      chk($sformatf("%s[%0d].w", nm, i), 32'(words_loaded), 32'(tbl[i].w));
      in_valid = tbl[i].v;
      in_data = tbl[i].d;
      @(negedge clk);
    end
    in_valid = 1'b0;
    tbl.delete();
  endtask

  task automatic send(input logic [7:0] b);
    in_valid = 1'b1;
    in_data = b;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic rd(input string nm, input logic [5:0] a,
                    input logic [31:0] exp);
    addr = a;
    #1;
    chk(nm, q, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic reset_and_clear();
    do_reset();
    repeat (64) @(negedge clk);
  endtask

  task automatic all_zero(input string nm);
    int nz = 0;
    for (int a = 0; a < 64; a++) begin
      addr = 6'(a);
      #1;
      if (q !== 32'h0) nz++;
    end
    chk(nm, 32'(nz), 32'd0);
  endtask

  initial begin
    // 1: clear phase timing
    do_reset();
    for (int i = 0; i < 70; i++) begin
      if (i == 0 || i == 63 || i == 64 || i == 69) begin
        chk($sformatf("clr.rdy%0d", i), 32'(in_ready), 32'(i >= 64));
        chk($sformatf("clr.cr%0d", i), 32'(cpu_reset), 32'd1);
      end else if (in_ready !== (i >= 64)) begin
        chk($sformatf("clr.rdy%0d", i), 32'(in_ready), 32'(i >= 64));
      end
      if (i < 69) @(negedge clk);
    end
    all_zero("clr.zero");
    chk("clr.w", 32'(words_loaded), 32'd0);

`ifndef IMEM_LOADER_CHECKSUM_EN
    // 2: two-word program
    reset_and_clear();
    tbl.push_back(mk(1, 8'h02, 1, 1, 0, 0, 0));
    tbl.push_back(mk(1, 8'h01, 1, 1, 0, 0, 0));
    tbl.push_back(mk(1, 8'h00, 1, 1, 0, 0, 0));
    tbl.push_back(mk(1, 8'h00, 1, 1, 0, 0, 0));
    tbl.push_back(mk(1, 8'hF8, 1, 1, 0, 0, 0));
    tbl.push_back(mk(1, 8'h02, 1, 1, 0, 0, 1));
    tbl.push_back(mk(1, 8'h80, 1, 1, 0, 0, 1));
    tbl.push_back(mk(1, 8'h00, 1, 1, 0, 0, 1));
    tbl.push_back(mk(1, 8'hF8, 1, 1, 0, 0, 1));
    tbl.push_back(mk(0, 8'h00, 0, 0, 1, 0, 2));
    tbl.push_back(mk(1, 8'h55, 0, 0, 1, 0, 2));
    tbl.push_back(mk(0, 8'h00, 0, 0, 1, 0, 2));
    run_tbl("two");
    rd("two.m0", 6'd0, 32'hF800_0001);
    rd("two.m1", 6'd1, 32'hF800_8002);
    rd("two.m2", 6'd2, 32'h0);
`endif

    // 3: oversize header
    reset_and_clear();
    tbl.push_back(mk(1, 8'h41, 1, 1, 0, 0, 0));
    tbl.push_back(mk(1, 8'h02, 0, 1, 0, 1, 0));
    tbl.push_back(mk(1, 8'h03, 0, 1, 0, 1, 0));
    tbl.push_back(mk(0, 8'h00, 0, 1, 0, 1, 0));
    run_tbl("big");
    rd("big.m0", 6'd0, 32'h0);

`ifndef IMEM_LOADER_CHECKSUM_EN
    // 4: stall mid-word
    reset_and_clear();
    send(8'h01);
    send(8'hAA);
    send(8'hBB);
    for (int i = 0; i < 20; i++) begin
      addr = 6'd0;
      #1;
      if (i == 0 || i == 19 || q !== 32'h0)
        chk($sformatf("gap.q%0d", i), q, 32'h0);
      @(negedge clk);
    end
    chk("gap.rdy", 32'(in_ready), 32'd1);
    chk("gap.w", 32'(words_loaded), 32'd0);
    send(8'hCC);
    rd("gap.mid", 6'd0, 32'h0);
    send(8'hDD);
    rd("gap.m0", 6'd0, 32'hDDCC_BBAA);
    chk("gap.dn", 32'(load_done), 32'd1);
    chk("gap.cr", 32'(cpu_reset), 32'd0);
    chk("gap.w1", 32'(words_loaded), 32'd1);
`else
    // 5: checksum good and bad
    reset_and_clear();
    send(8'h01); send(8'h01); send(8'h00); send(8'h00); send(8'hF8);
    chk("cs.rdy", 32'(in_ready), 32'd1);
    chk("cs.pre", 32'(load_done), 32'd0);
    send(8'hF8);
    chk("cs.dn", 32'(load_done), 32'd1);
    chk("cs.cr", 32'(cpu_reset), 32'd0);
    rd("cs.m0", 6'd0, 32'hF800_0001);
    reset_and_clear();
    send(8'h01); send(8'h01); send(8'h00); send(8'h00); send(8'hF8);
    send(8'hF9);
    chk("csb.er", 32'(load_err), 32'd1);
    chk("csb.dn", 32'(load_done), 32'd0);
    chk("csb.cr", 32'(cpu_reset), 32'd1);
    rd("csb.m0", 6'd0, 32'hF800_0001);
`endif

    // 6: reset in the middle of a load
    reset_and_clear();
    send(8'h04);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    send(8'h55); send(8'h66); send(8'h77); send(8'h88);
    chk("mid.w", 32'(words_loaded), 32'd2);
    rd("mid.m1", 6'd1, 32'h8877_6655);
    reset = 1'b1;
    @(negedge clk);
    chk("mid.cr", 32'(cpu_reset), 32'd1);
    chk("mid.rdy0", 32'(in_ready), 32'd0);
    chk("mid.w0", 32'(words_loaded), 32'd0);
    reset = 1'b0;
    repeat (64) @(negedge clk);
    chk("mid.rdy1", 32'(in_ready), 32'd1);
    all_zero("mid.zero");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
